// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped instruction cache.
package inst_cache_pkg;
   localparam int WORD_SIZE   = 32;
   localparam int BLOCK_SIZE  = 1024;
   localparam int LINE_BYTES  = 128;
   localparam int OFFSET_BITS = 7;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;
endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
module inst_cache_array #(
   parameter int BLOCK_SIZE = 1024,
   parameter int NUM_LINES  = 8,
   parameter int TAG_BITS   = 22,
   parameter int IDX_BITS   = $clog2(NUM_LINES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_BITS-1:0]   rd_idx,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [BLOCK_SIZE-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [IDX_BITS-1:0]   wr_idx,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [BLOCK_SIZE-1:0] wr_data
);
   logic [NUM_LINES-1:0]  valid;
   logic [TAG_BITS-1:0]   tags [NUM_LINES];
   logic [BLOCK_SIZE-1:0] data [NUM_LINES];

   // Only the valid bits need a reset; stale tag/data are masked by valid.
   always_ff @(posedge clk) begin
      if (rst)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational lookup, single-beat line refill FSM.
module inst_cache #(
   parameter int WORD_SIZE  = inst_cache_pkg::WORD_SIZE,
   parameter int BLOCK_SIZE = inst_cache_pkg::BLOCK_SIZE,
   parameter int NUM_LINES  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_SIZE-1:0]  in,
   output logic [BLOCK_SIZE-1:0] out,
   output logic                  miss,
   output logic                  mem_req,
   output logic [WORD_SIZE-1:0]  mem_addr,
   input  logic                  mem_valid,
   input  logic [BLOCK_SIZE-1:0] mem_rdata
);
   import inst_cache_pkg::*;

   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = WORD_SIZE - OFFSET_BITS - IDX_BITS;

   state_t                state_q, state_d;
   logic                  req_d;
   logic [WORD_SIZE-1:0]  addr_d;
   logic                  wr_en;
   logic                  hit;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [BLOCK_SIZE-1:0] rd_data;
   logic [IDX_BITS-1:0]   idx_in;
   logic [TAG_BITS-1:0]   tag_in;
   logic                  unused_offset;

   assign idx_in        = in[OFFSET_BITS +: IDX_BITS];
   assign tag_in        = in[WORD_SIZE-1 -: TAG_BITS];
   assign unused_offset = ^in[OFFSET_BITS-1:0];

   inst_cache_array #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .NUM_LINES  (NUM_LINES),
      .TAG_BITS   (TAG_BITS),
      .IDX_BITS   (IDX_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx_in),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (mem_addr[OFFSET_BITS +: IDX_BITS]),
      .wr_tag   (mem_addr[WORD_SIZE-1 -: TAG_BITS]),
      .wr_data  (mem_rdata)
   );

   // A refill in progress always reports a miss, even if the line is resident.
   assign hit  = rd_valid && (rd_tag == tag_in) && (state_q == IDLE);
   assign miss = !hit;
   assign out  = hit ? rd_data : '0;

   always_comb begin
      state_d = state_q;
      req_d   = mem_req;
      addr_d  = mem_addr;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss) begin
               state_d = FILL;
               req_d   = 1'b1;
               addr_d  = {in[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
         end
         FILL: begin
            if (mem_valid) begin
               wr_en   = !rst;
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         state_q  <= state_d;
         mem_req  <= req_d;
         mem_addr <= addr_d;
      end
   end
endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache against a line-address reference model.
module tb_inst_cache;
   localparam int W = 32;
   localparam int B = 1024;
   localparam int N = 8;

   typedef struct {
      logic         miss;
      logic [B-1:0] out;
      logic         req;
      logic [W-1:0] addr;
      logic [W-1:0] pc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in;
   logic [B-1:0] out;
   logic         miss;
   logic         mem_req;
   logic [W-1:0] mem_addr;
   logic         mem_valid;
   logic [B-1:0] mem_rdata;

   int passed = 0;
   int total  = 0;
   int nfail  = 0;

   exp_t sb[$];

   // Reference model: which line address each slot holds, plus one pending refill.
   bit           lv [N];
   logic [W-1:0] la [N];
   bit           busy;
   logic [W-1:0] faddr;
   int           cnt;
   int           lat;

   always #5 clk = ~clk;

   function automatic logic [B-1:0] pattern(input logic [W-1:0] a);
      logic [B-1:0] r;
      logic [31:0]  w;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         w = (a * 32'h9E3779B1) ^ (i * 32'h01000193) ^ 32'h5BD1E995;
         if (a == 0 && i == 0) w = 32'h80100003;
         r[B-1-32*i -: 32] = w;
      end
      return r;
   endfunction

   assign mem_rdata = pattern(mem_addr);

   inst_cache #(.WORD_SIZE(W), .BLOCK_SIZE(B), .NUM_LINES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .out       (out),
      .miss      (miss),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_valid (mem_valid),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string nm, input logic [B-1:0] got, input logic [B-1:0] want,
                      input logic [W-1:0] pc);
      total++;
      if (got === want) passed++;
      else begin
         nfail++;
         if (nfail <= 20) begin
            for (int i = 0; i < 32; i++) begin
               if (got[32*i +: 32] !== want[32*i +: 32]) begin
                  $display("FAIL %s pc=%h bits[%0d+:32] got=%h want=%h t=%0t",
                           nm, pc, 32*i, got[32*i +: 32], want[32*i +: 32], $time);
                  break;
               end
            end
         end
      end
   endtask

   // Monitor: DUT outputs are sampled on the falling edge and matched in order.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() == 0) begin
            total++;
            nfail++;
            $display("FAIL scoreboard empty at t=%0t got=0 entries want>=1", $time);
         end else begin
            e = sb.pop_front();
            chk("miss",     B'(miss),     B'(e.miss), e.pc);
            chk("out",      out,          e.out,      e.pc);
            chk("mem_req",  B'(mem_req),  B'(e.req),  e.pc);
            chk("mem_addr", B'(mem_addr), B'(e.addr), e.pc);
         end
      end
   end

   task automatic cyc(input logic [W-1:0] pc, input bit r, input bit spur);
      exp_t         e;
      bit           mv;
      bit           m;
      logic [W-1:0] l;
      int           ix;
      @(posedge clk);
      #1;
      mv = busy ? (cnt >= lat) : spur;
      in        = pc;
      rst       = r;
      mem_valid = mv;
      l  = {pc[W-1:7], 7'b0};
      ix = int'(l[9:7]);
      m  = busy || !(lv[ix] && la[ix] == l);
      e.miss = m;
      e.out  = m ? '0 : pattern(l);
      e.req  = busy;
      e.addr = faddr;
      e.pc   = pc;
      sb.push_back(e);
      if (busy) cnt++;
      if (r) begin
         for (int i = 0; i < N; i++) lv[i] = 1'b0;
         busy  = 1'b0;
         faddr = '0;
         cnt   = 0;
      end else if (!busy && m) begin
         busy  = 1'b1;
         faddr = l;
         cnt   = 0;
      end else if (busy && mv) begin
         lv[int'(faddr[9:7])] = 1'b1;
         la[int'(faddr[9:7])] = faddr;
         busy = 1'b0;
      end
   endtask

   task automatic go(input logic [W-1:0] pc);
      cyc(pc, 1'b0, 1'b0);
      while (busy) cyc(pc, 1'b0, 1'b0);
      cyc(pc, 1'b0, 1'b0);
   endtask

   initial begin
      logic [W-1:0] pc;
      rst       = 1'b1;
      in        = '0;
      mem_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         lv[i] = 1'b0;
         la[i] = '0;
      end
      busy  = 1'b0;
      faddr = '0;
      cnt   = 0;
      lat   = 5;

      // cold miss, same-line hit, conflict eviction
      go(32'h0000_0000);
      cyc(32'h0000_007C, 1'b0, 1'b0);
      cyc(32'h0000_0040, 1'b0, 1'b0);
      go(32'h0000_0080);
      go(32'h0000_0400);
      go(32'h0000_0000);

      // PC moves while a refill is outstanding
      lat = 3;
      cyc(32'h0000_0100, 1'b0, 1'b0);
      while (busy) cyc(32'h0000_0200, 1'b0, 1'b0);
      go(32'h0000_0200);
      go(32'h0000_0100);

      // reset during FILL, then a late mem_valid pulse
      lat = 6;
      cyc(32'h0000_0300, 1'b0, 1'b0);
      cyc(32'h0000_0300, 1'b0, 1'b0);
      cyc(32'h0000_0300, 1'b1, 1'b0);
      cyc(32'h0000_0300, 1'b0, 1'b1);
      while (busy) cyc(32'h0000_0300, 1'b0, 1'b0);
      go(32'h0000_0300);

      // spurious mem_valid while idle on a hit
      cyc(32'h0000_0310, 1'b0, 1'b1);
      cyc(32'h0000_037C, 1'b0, 1'b1);
      cyc(32'h0000_0300, 1'b0, 1'b0);

      pc = 32'h0;
      repeat (3000) begin
         if (!busy) lat = $urandom_range(0, 6);
         if ($urandom_range(0, 2) == 0) begin
            pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 7)
                 | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) pc[31:12] = 20'($urandom);
         end else begin
            pc[6:0] = 7'($urandom_range(0, 127));
         end
         cyc(pc, $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
